hazard_forwarding_unit: RTL and testbench
=========================================

Name: hazard_forwarding_unit

Overview:
- Sits in the ID stage, directly upstream of the control-unit NOP multiplexer and the ID-stage four-to-one operand multiplexers.
- Tracks destination-register and write-enable state for the EX, MEM and WB stages in an internal shadow pipeline.
- Drives the NOP-insertion selector, the PC and IF/ID load enables, and the two operand-forwarding selectors.
- Keeps a saturating stall counter for performance debug.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
ID_rs1  input  REG_ADDR_W  source register 1 of instruction in ID
ID_rs2  input  REG_ADDR_W  source register 2 of instruction in ID
ID_uses_rs1  input  1  instruction in ID reads rs1
ID_uses_rs2  input  1  instruction in ID reads rs2
ID_rd  input  REG_ADDR_W  destination register of instruction in ID
ID_RF_Enable  input  1  instruction in ID writes the register file (post-mux value)
ID_Load_Instr  input  1  instruction in ID is a load (post-mux value)
flush  input  1  taken branch/jump resolved this cycle; squash instruction in ID
CU_mux_sel  output  1  1 = control mux outputs all-zero bubble
PC_LE  output  1  PC load enable
IF_ID_LE  output  1  IF/ID register load enable
IF_ID_clear  output  1  clear IF/ID register to NOP
fwd_a_sel  output  2  rs1 operand mux select: 00 RF, 01 EX result, 10 MEM result, 11 WB result
fwd_b_sel  output  2  rs2 operand mux select, same encoding
stall_count  output  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n); all state updates on the rising edge of clk.
- State: EX_rd, EX_we, EX_load; MEM_rd, MEM_we; WB_rd, WB_we; stall_count.
- Reset (rst_n=0 at edge): all rd fields 0, all we/load bits 0, stall_count 0.
- While rst_n=0, outputs are forced: CU_mux_sel=0, PC_LE=1, IF_ID_LE=1, IF_ID_clear=0, fwd_a_sel=fwd_b_sel=00.
- Reset mid-stall discards the pending stall; the first post-reset cycle has no hazard.
- Effective writes: a stage counts as writing only if we=1 and rd!=0. x0 is never forwarded and never stalls.
- Load-use hazard (combinational), stall = EX_we & EX_load & EX_rd!=0 & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)).
- stall=1 -> CU_mux_sel=1, PC_LE=0, IF_ID_LE=0; one bubble per stall cycle.
- Forwarding for rs1 (rs2 identical using ID_uses_rs2/ID_rs2):
  - If not used -> 00.
  - Else priority: EX match and not EX_load -> 01; MEM match -> 10; WB match -> 11; else 00.
  - An EX load match yields 00 and raises stall instead.
- flush=1 -> IF_ID_clear=1, CU_mux_sel=1. PC_LE=1 and IF_ID_LE=1 regardless of stall; flush wins over stall.
- Shadow pipeline advance, every edge with rst_n=1:
  - MEM<=EX, WB<=MEM.
  - EX<=bubble (rd 0, we 0, load 0) if stall or flush; else EX<={ID_rd, ID_RF_Enable, ID_Load_Instr}.
- Latency: hazard outputs are combinational from current state and ID inputs (zero-cycle). Tracked state lags one cycle per stage.
- stall_count increments by 1 on each edge where stall=1 and flush=0. It holds at 2^CNT_W-1 (no wrap).
- A load followed by a dependent instruction gives exactly one stall cycle. In the next cycle the load is in MEM and the select is 10.

Test Plan:
- Reset: hold rst_n=0 two cycles with ID_rs1=3 matching stale EX -> fwd_a_sel=00, PC_LE=1, CU_mux_sel=0, stall_count=0.
- ALU dependency: cycle n ID writes x5 (RF_Enable=1, load=0); cycle n+1 ID_rs1=5 -> fwd_a_sel=01; n+2 -> 10; n+3 -> 11; n+4 -> 00.
- Load-use: cycle n load to x7; cycle n+1 ID_rs2=7 -> CU_mux_sel=1, PC_LE=0, IF_ID_LE=0, stall_count 0->1; cycle n+2 same inputs -> no stall, fwd_b_sel=10.
- x0 and priority: writes to x0 then rs1=0 -> 00, no stall. x9 written in consecutive instructions, then rs1=9 -> 01 (EX beats MEM).
- Flush during stall: load to x4, then ID_rs1=4 with flush=1 -> IF_ID_clear=1, CU_mux_sel=1, PC_LE=1, stall_count unchanged; next cycle EX_we=0.
- Saturation: CNT_W=2, force 5 consecutive load-use stalls -> stall_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forwarding_unit
//  Description : ID-stage load-use stall detection and EX/MEM/WB operand
//                forwarding, with a saturating stall counter.
//  Revision    : 1.0
// ============================================================================
module hazard_forwarding_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic                  ID_uses_rs1,
    input  logic                  ID_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ID_rd,
    input  logic                  ID_RF_Enable,
    input  logic                  ID_Load_Instr,
    input  logic                  flush,
    output logic                  CU_mux_sel,
    output logic                  PC_LE,
    output logic                  IF_ID_LE,
    output logic                  IF_ID_clear,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0]       c_FWD_RF  = 2'b00;
    localparam logic [1:0]       c_FWD_EX  = 2'b01;
    localparam logic [1:0]       c_FWD_MEM = 2'b10;
    localparam logic [1:0]       c_FWD_WB  = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_we;
    logic                  r_ex_load;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_we;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_we;
    logic [CNT_W-1:0]      r_stall_count;

    logic       w_ex_wr;
    logic       w_mem_wr;
    logic       w_wb_wr;
    logic       w_haz_a;
    logic       w_haz_b;
    logic       w_stall;
    logic       w_bubble_ex;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A stage only counts as a producer when it writes a register other than x0
    assign w_ex_wr  = r_ex_we  && (r_ex_rd  != '0);
    assign w_mem_wr = r_mem_we && (r_mem_rd != '0);
    assign w_wb_wr  = r_wb_we  && (r_wb_rd  != '0);

    // A load in EX has no result yet, so a match there selects RF and stalls instead
    function automatic logic [1:0] fwd_select(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_wr,
        input logic                  ex_load,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (used) begin
            if (ex_wr && (rs == ex_rd)) begin
                sel = ex_load ? c_FWD_RF : c_FWD_EX;
            end else if (mem_wr && (rs == mem_rd)) begin
                sel = c_FWD_MEM;
            end else if (wb_wr && (rs == wb_rd)) begin
                sel = c_FWD_WB;
            end
        end
        return sel;
    endfunction

    assign w_fwd_a = fwd_select(ID_uses_rs1, ID_rs1, w_ex_wr, r_ex_load, r_ex_rd,
                                w_mem_wr, r_mem_rd, w_wb_wr, r_wb_rd);
    assign w_fwd_b = fwd_select(ID_uses_rs2, ID_rs2, w_ex_wr, r_ex_load, r_ex_rd,
                                w_mem_wr, r_mem_rd, w_wb_wr, r_wb_rd);

    assign w_haz_a     = ID_uses_rs1 && (ID_rs1 == r_ex_rd);
    assign w_haz_b     = ID_uses_rs2 && (ID_rs2 == r_ex_rd);
    assign w_stall     = w_ex_wr && r_ex_load && (w_haz_a || w_haz_b);
    assign w_bubble_ex = w_stall || flush;

    always_comb begin
        CU_mux_sel  = 1'b0;
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        IF_ID_clear = 1'b0;
        fwd_a_sel   = c_FWD_RF;
        fwd_b_sel   = c_FWD_RF;
        if (rst_n) begin
            fwd_a_sel = w_fwd_a;
            fwd_b_sel = w_fwd_b;
            // A squashed instruction must not freeze fetch, so flush overrides stall
            if (flush) begin
                CU_mux_sel  = 1'b1;
                IF_ID_clear = 1'b1;
            end else if (w_stall) begin
                CU_mux_sel = 1'b1;
                PC_LE      = 1'b0;
                IF_ID_LE   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rd       <= '0;
            r_ex_we       <= 1'b0;
            r_ex_load     <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_we      <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_we       <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_mem_rd <= r_ex_rd;
            r_mem_we <= r_ex_we;
            r_wb_rd  <= r_mem_rd;
            r_wb_we  <= r_mem_we;
            if (w_bubble_ex) begin
                r_ex_rd   <= '0;
                r_ex_we   <= 1'b0;
                r_ex_load <= 1'b0;
            end else begin
                r_ex_rd   <= ID_rd;
                r_ex_we   <= ID_RF_Enable;
                r_ex_load <= ID_Load_Instr;
            end
            if (w_stall && !flush && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forwarding_unit
//  Description : Directed and randomised stimulus checked against an
//                instruction-history model of the hazard/forwarding rules.
//  Revision    : 1.0
// ============================================================================
module tb_hazard_forwarding_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ID_rs1, ID_rs2, ID_rd;
    logic       ID_uses_rs1, ID_uses_rs2, ID_RF_Enable, ID_Load_Instr, flush;

    logic        cu, pc_le, ifid_le, ifid_clr;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
    logic        s_cu, s_pc_le, s_ifid_le, s_ifid_clr;
    logic [1:0]  s_fa, s_fb;
    logic [1:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_forwarding_unit #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_rd(ID_rd), .ID_RF_Enable(ID_RF_Enable), .ID_Load_Instr(ID_Load_Instr), .flush(flush),
        .CU_mux_sel(cu), .PC_LE(pc_le), .IF_ID_LE(ifid_le), .IF_ID_clear(ifid_clr),
        .fwd_a_sel(fa), .fwd_b_sel(fb), .stall_count(cnt)
    );

    hazard_forwarding_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_rd(ID_rd), .ID_RF_Enable(ID_RF_Enable), .ID_Load_Instr(ID_Load_Instr), .flush(flush),
        .CU_mux_sel(s_cu), .PC_LE(s_pc_le), .IF_ID_LE(s_ifid_le), .IF_ID_clear(s_ifid_clr),
        .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall_count(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of issued instructions by age (1 = issued last cycle, now in EX)
    logic [4:0] h_rd [1:3];
    logic       h_we [1:3];
    logic       h_ld [1:3];
    int         m_cnt  = 0;
    int         m_cnt2 = 0;
    bit         model_ok = 0;

    // Youngest in-flight producer wins; its age is the forwarding code.
    function automatic logic [1:0] m_sel(input logic used, input logic [4:0] rs, output logic hz);
        hz = 1'b0;
        if (!used || rs == 5'd0) return 2'd0;
        for (int age = 1; age <= 3; age++) begin
            if (h_we[age] && h_rd[age] == rs) begin
                if (age == 1 && h_ld[1]) begin
                    hz = 1'b1;
                    return 2'd0;
                end
                return 2'(age);
            end
        end
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        logic [1:0] sa, sb;
        logic       ha, hb;
        if (!rst_n) begin
            for (int i = 1; i <= 3; i++) begin
                h_rd[i] <= 5'd0; h_we[i] <= 1'b0; h_ld[i] <= 1'b0;
            end
            m_cnt    <= 0;
            m_cnt2   <= 0;
            model_ok <= 1;
        end else if (model_ok) begin
            sa = m_sel(ID_uses_rs1, ID_rs1, ha);
            sb = m_sel(ID_uses_rs2, ID_rs2, hb);
            if ((ha || hb) && !flush) begin
                m_cnt  <= (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
                m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
            h_rd[3] <= h_rd[2]; h_we[3] <= h_we[2]; h_ld[3] <= h_ld[2];
            h_rd[2] <= h_rd[1]; h_we[2] <= h_we[1]; h_ld[2] <= h_ld[1];
            if ((ha || hb) || flush) begin
                h_rd[1] <= 5'd0; h_we[1] <= 1'b0; h_ld[1] <= 1'b0;
            end else begin
                h_rd[1] <= ID_rd; h_we[1] <= ID_RF_Enable; h_ld[1] <= ID_Load_Instr;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        logic [1:0] ea, eb;
        logic       ha, hb, st;
        logic       e_cu, e_pc, e_clr;
        if (model_ok) begin
            ea = m_sel(ID_uses_rs1, ID_rs1, ha);
            eb = m_sel(ID_uses_rs2, ID_rs2, hb);
            st = ha || hb;
            if (!rst_n) begin
                ea = 2'd0; eb = 2'd0; e_cu = 1'b0; e_pc = 1'b1; e_clr = 1'b0;
            end else begin
                e_cu  = st || flush;
                e_pc  = flush || !st;
                e_clr = flush;
            end
            chk("fwd_a_sel", 32'(fa), 32'(ea));
            chk("fwd_b_sel", 32'(fb), 32'(eb));
            chk("CU_mux_sel", 32'(cu), 32'(e_cu));
            chk("PC_LE", 32'(pc_le), 32'(e_pc));
            chk("IF_ID_LE", 32'(ifid_le), 32'(e_pc));
            chk("IF_ID_clear", 32'(ifid_clr), 32'(e_clr));
            chk("stall_count", 32'(cnt), 32'(m_cnt));
            chk("sat_stall_count", 32'(s_cnt), 32'(m_cnt2));
            chk("sat_fwd", 32'({s_fa, s_fb}), 32'({ea, eb}));
            chk("sat_ctrl", 32'({s_cu, s_pc_le, s_ifid_le, s_ifid_clr}),
                32'({e_cu, e_pc, e_pc, e_clr}));
        end
    end

    task automatic cyc(input logic rs, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
        @(posedge clk);
        #1;
        rst_n = rs; ID_rs1 = r1; ID_uses_rs1 = u1; ID_rs2 = r2; ID_uses_rs2 = u2;
        ID_rd = rd; ID_RF_Enable = we; ID_Load_Instr = ld; flush = fl;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0;
        ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_RF_Enable = 0; ID_Load_Instr = 0; flush = 0;

        // Reset with a would-be dependency present
        cyc(0, 3, 1, 0, 0, 3, 1, 0, 0);
        cyc(0, 3, 1, 0, 0, 3, 1, 0, 0);
        chk("rst_fwd_a", 32'(fa), 32'd0);
        chk("rst_pc_le", 32'(pc_le), 32'd1);
        chk("rst_cu", 32'(cu), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);

        // ALU dependency on x5 walks EX -> MEM -> WB -> RF
        cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0); chk("alu_ex", 32'(fa), 32'd1);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0); chk("alu_mem", 32'(fa), 32'd2);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0); chk("alu_wb", 32'(fa), 32'd3);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0); chk("alu_rf", 32'(fa), 32'd0);

        // Load-use on x7 through rs2
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0);
        cyc(1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("lu_cu", 32'(cu), 32'd1);
        chk("lu_pc", 32'(pc_le), 32'd0);
        chk("lu_ifid", 32'(ifid_le), 32'd0);
        chk("lu_cnt0", 32'(cnt), 32'd0);
        cyc(1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("lu_nostall", 32'(cu), 32'd0);
        chk("lu_fwd_b", 32'(fb), 32'd2);
        chk("lu_cnt1", 32'(cnt), 32'd1);

        // x0 is never a producer, even for a load
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("x0_fwd", 32'({fa, fb}), 32'd0);
        chk("x0_cu", 32'(cu), 32'd0);

        // EX beats MEM for back-to-back writes of x9
        cyc(1, 0, 0, 0, 0, 9, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 9, 1, 0, 0);
        cyc(1, 9, 1, 9, 1, 0, 0, 0, 0);
        chk("prio_a", 32'(fa), 32'd1);
        chk("prio_b", 32'(fb), 32'd1);

        // Flush during a load-use stall; flushed writer of x6 must not enter EX
        cyc(1, 0, 0, 0, 0, 4, 1, 1, 0);
        cyc(1, 4, 1, 0, 0, 6, 1, 0, 1);
        chk("fl_clear", 32'(ifid_clr), 32'd1);
        chk("fl_cu", 32'(cu), 32'd1);
        chk("fl_pc", 32'(pc_le), 32'd1);
        chk("fl_ifid", 32'(ifid_le), 32'd1);
        cyc(1, 6, 1, 4, 1, 0, 0, 0, 0);
        chk("fl_cnt", 32'(cnt), 32'd1);
        chk("fl_bubble", 32'(fa), 32'd0);
        chk("fl_mem", 32'(fb), 32'd2);

        // Reset in the middle of a load-use stall
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
        cyc(0, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("rs_cu", 32'(cu), 32'd0);
        chk("rs_pc", 32'(pc_le), 32'd1);
        cyc(0, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("rs_cnt", 32'(cnt), 32'd0);
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("rs_post_fwd", 32'(fa), 32'd0);
        chk("rs_post_cu", 32'(cu), 32'd0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0, 8, 1, 1, 0);
            cyc(1, 8, 1, 0, 0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("sat_seq", 32'(s_cnt), 32'((i < 3) ? i + 1 : 3));
        end
        chk("sat_main", 32'(cnt), 32'd5);

        // Randomised traffic on a small register window
        for (int i = 0; i < 300; i++) begin
            cyc(1, 5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
